// File: rtl/ahb_lite_master_bridge_if.sv
// Signal bundle between the core load/store unit, the bridge and the AHB-Lite bus.
// Handshake: the core holds req_i and its payload stable until gnt_o; a request moves on the cycle where req_i and gnt_o are both high. rvalid_o is a one-cycle pulse with no backpressure.
interface ahb_lite_master_bridge_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              req_i;
    logic              we_i;
    logic [2:0]        size_i;
    logic [AWIDTH-1:0] addr_i;
    logic [DWIDTH-1:0] wdata_i;
    logic              gnt_o;
    logic              rvalid_o;
    logic              err_o;
    logic [DWIDTH-1:0] rdata_o;

    logic [AWIDTH-1:0] haddr_o;
    logic [1:0]        htrans_o;
    logic              hwrite_o;
    logic [2:0]        hsize_o;
    logic [2:0]        hburst_o;
    logic [DWIDTH-1:0] hwdata_o;
    logic              hready_i;
    logic              hresp_i;
    logic [DWIDTH-1:0] hrdata_i;

    modport master (
        input  req_i, we_i, size_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, err_o, rdata_o,
        output haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o, hwdata_o,
        input  hready_i, hresp_i, hrdata_i
    );

    modport slave (
        output req_i, we_i, size_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, err_o, rdata_o,
        input  haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o, hwdata_o,
        output hready_i, hresp_i, hrdata_i
    );
endinterface

// File: rtl/ahb_lite_master_bridge.sv
// Turns core request/grant/response traffic into single NONSEQ AHB-Lite transfers,
// one at a time, rejecting misaligned or oversized requests without using the bus.
module ahb_lite_master_bridge #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic                     hclk,
    input  logic                     hreset,
    ahb_lite_master_bridge_if.master bus,
    output logic [1:0]               dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              legal;
    logic              gnt;
    logic              rej_q;
    logic              done_ok, done_err;
    logic [1:0]        htrans_q;
    logic [AWIDTH-1:0] haddr_q;
    logic              hwrite_q;
    logic [2:0]        hsize_q;
    logic [DWIDTH-1:0] hwdata_q, wbuf_q, rdata_q;
    logic              rvalid_q, err_q;

    always_comb begin
        legal = 1'b0;
        case (bus.size_i)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~bus.addr_i[0];
            3'b010:  legal = (bus.addr_i[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // A local reject's response cycle must not overlap a new acceptance.
    assign gnt = bus.req_i & (state_q == S_IDLE) & ~hreset & ~rej_q;

    always_comb begin
        state_d  = state_q;
        done_ok  = 1'b0;
        done_err = 1'b0;
        case (state_q)
            S_IDLE: if (gnt && legal) state_d = S_ADDR;
            S_ADDR: if (bus.hready_i) state_d = S_DATA;
            S_DATA: begin
                if (bus.hready_i) begin
                    state_d = S_IDLE;
                    if (bus.hresp_i) done_err = 1'b1;
                    else             done_ok  = 1'b1;
                end else if (bus.hresp_i) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: if (bus.hready_i) begin
                state_d  = S_IDLE;
                done_err = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q  <= S_IDLE;
            rej_q    <= 1'b0;
            htrans_q <= 2'b00;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= 3'b000;
            hwdata_q <= '0;
            wbuf_q   <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rej_q    <= gnt & ~legal;
            rvalid_q <= done_ok | done_err | (gnt & ~legal);
            err_q    <= done_err | (gnt & ~legal);
            rdata_q  <= (done_ok && !hwrite_q) ? bus.hrdata_i : '0;
            if (gnt && legal) begin
                haddr_q  <= bus.addr_i;
                hwrite_q <= bus.we_i;
                hsize_q  <= bus.size_i;
                wbuf_q   <= bus.wdata_i;
                htrans_q <= 2'b10;
            end
            // Write data moves onto the bus as the address phase is accepted.
            if (state_q == S_ADDR && bus.hready_i) begin
                htrans_q <= 2'b00;
                if (hwrite_q) hwdata_q <= wbuf_q;
            end
        end
    end

    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = rvalid_q;
    assign bus.err_o    = err_q;
    assign bus.rdata_o  = rdata_q;
    assign bus.haddr_o  = haddr_q;
    assign bus.htrans_o = htrans_q;
    assign bus.hwrite_o = hwrite_q;
    assign bus.hsize_o  = hsize_q;
    assign bus.hburst_o = 3'b000;
    assign bus.hwdata_o = hwdata_q;
    assign dbg_state    = state_q;
endmodule
